mem_stage: RTL and testbench

Memory stage of the RI5CY-derived core, directly downstream of the execute stage. It consumes the execute result (effective address or ALU result) and the store operand. Loads and stores run over a request/grant/rvalid data-memory handshake; non-memory results pass through. The stage registers one writeback result per instruction for the writeback stage.

---
 rtl/riscv_defines.sv | 34 +++
 rtl/mem_stage_lsu_align.sv | 46 ++++
 rtl/mem_stage.sv | 130 +++++++++++++
 tb/tb_mem_stage.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
// Shared core definitions: word width, memory access size encodings and the
// memory-stage FSM state type, plus small offset helpers used by the LSU path.
package riscv_defines;

  localparam int unsigned WORD_WIDTH = 32;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    WAIT_GNT    = 2'b01,
    WAIT_RVALID = 2'b10
  } mem_state_t;

  // Clears the offset bits below the access size so the access proceeds aligned.
  function automatic logic [1:0] align_offset(input logic [1:0] off, input logic [1:0] size);
    case (size)
      MEM_BYTE: align_offset = off;
      MEM_HALF: align_offset = {off[1], 1'b0};
      default:  align_offset = 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] size);
    case (size)
      MEM_BYTE: is_misaligned = 1'b0;
      MEM_HALF: is_misaligned = off[0];
      default:  is_misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational LSU alignment: byte enables and store-data lane replication on
// the request side, load-data extraction and sign/zero extension on the response side.
module lsu_align
  import riscv_defines::*;
(
  input  logic [1:0]            addr_off,
  input  logic [1:0]            size,
  input  logic [WORD_WIDTH-1:0] wdata_raw,
  output logic [3:0]            be,
  output logic [WORD_WIDTH-1:0] wdata,
  input  logic [1:0]            rd_off,
  input  logic [1:0]            rd_size,
  input  logic                  rd_unsigned,
  input  logic [WORD_WIDTH-1:0] rdata,
  output logic [WORD_WIDTH-1:0] rd_ext
);

  logic [WORD_WIDTH-1:0] shifted;

  always_comb begin
    be    = 4'b1111;
    wdata = wdata_raw;
    case (size)
      MEM_BYTE: begin
        be    = 4'b0001 << addr_off;
        wdata = {4{wdata_raw[7:0]}};
      end
      MEM_HALF: begin
        be    = 4'b0011 << {addr_off[1], 1'b0};
        wdata = {2{wdata_raw[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = rdata >> {rd_off, 3'b000};
    rd_ext  = shifted;
    case (rd_size)
      MEM_BYTE: rd_ext = {{24{~rd_unsigned & shifted[7]}},  shifted[7:0]};
      MEM_HALF: rd_ext = {{16{~rd_unsigned & shifted[15]}}, shifted[15:0]};
      default:  ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: drives the req/gnt/rvalid data-memory handshake for loads and
// stores, passes ALU results through, registers one writeback result per op.
// Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
module mem_stage
  import riscv_defines::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_WIDTH-1:0] ex_data_i,
  input  logic [WORD_WIDTH-1:0] rdata2_store_i,
  input  logic                  ex_valid_i,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_size_i,
  input  logic                  mem_unsigned_i,
  output logic                  stall_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  output logic [WORD_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [WORD_WIDTH-1:0] data_wdata_o,
  input  logic [WORD_WIDTH-1:0] data_rdata_i,
  output logic [WORD_WIDTH-1:0] wb_data_o,
  output logic                  wb_valid_o,
  output logic                  misaligned_o
);

  mem_state_t            state_q, state_d;
  logic [1:0]            off_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic                  we_q;

  logic                  mem_start;
  logic                  misalign;
  logic                  issue;
  logic                  req;
  logic [1:0]            req_off;
  logic [3:0]            be;
  logic [WORD_WIDTH-1:0] wdata;
  logic [WORD_WIDTH-1:0] rd_ext;

  assign mem_start = ex_valid_i & mem_req_i & (state_q == IDLE);
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign  = mem_start & is_misaligned(ex_data_i[1:0], mem_size_i);
`else
  assign misalign  = 1'b0;
`endif
  assign issue     = mem_start & ~misalign;
  assign req       = issue | (state_q == WAIT_GNT);
  assign req_off   = align_offset(ex_data_i[1:0], mem_size_i);

  lsu_align u_lsu_align (
    .addr_off    (req_off),
    .size        (mem_size_i),
    .wdata_raw   (rdata2_store_i),
    .be          (be),
    .wdata       (wdata),
    .rd_off      (off_q),
    .rd_size     (size_q),
    .rd_unsigned (uns_q),
    .rdata       (data_rdata_i),
    .rd_ext      (rd_ext)
  );

  // Request fields come straight from the inputs, which upstream holds while stalled.
  assign data_req_o   = req;
  assign data_addr_o  = req ? {ex_data_i[WORD_WIDTH-1:2], 2'b00} : '0;
  assign data_we_o    = req & mem_we_i;
  assign data_be_o    = req ? be : '0;
  assign data_wdata_o = req ? wdata : '0;

  assign stall_o = issue | (state_q == WAIT_GNT) |
                   ((state_q == WAIT_RVALID) & ~data_rvalid_i);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (issue) state_d = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
      WAIT_GNT:    if (data_gnt_i) state_d = WAIT_RVALID;
      WAIT_RVALID: if (data_rvalid_i) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      off_q      <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      we_q       <= 1'b0;
      wb_data_o  <= '0;
      wb_valid_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_valid_o <= 1'b0;
      if (state_q == IDLE && ex_valid_i && !mem_req_i) begin
        wb_data_o  <= ex_data_i;
        wb_valid_o <= 1'b1;
      end
      if (issue) begin
        off_q  <= req_off;
        size_q <= mem_size_i;
        uns_q  <= mem_unsigned_i;
        we_q   <= mem_we_i;
      end
      if (state_q == WAIT_RVALID && data_rvalid_i) begin
        wb_valid_o <= 1'b1;
        if (!we_q) wb_data_o <= rd_ext;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misaligned_q <= 1'b0;
    else        misaligned_q <= misalign;
  end

  assign misaligned_o = misaligned_q;
`else
  assign misaligned_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: passthrough, loads, delayed-grant
// store, reset mid-transaction and the misaligned word load.
module tb_mem_stage;
  import riscv_defines::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [WORD_WIDTH-1:0] ex_data_i, rdata2_store_i, data_rdata_i;
  logic                  ex_valid_i, mem_req_i, mem_we_i, mem_unsigned_i;
  logic [1:0]            mem_size_i;
  logic                  data_gnt_i, data_rvalid_i;
  logic                  stall_o, data_req_o, data_we_o, wb_valid_o, misaligned_o;
  logic [WORD_WIDTH-1:0] data_addr_o, data_wdata_o, wb_data_o;
  logic [3:0]            data_be_o;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned req_cycles;

  mem_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_data_i      (ex_data_i),
    .rdata2_store_i (rdata2_store_i),
    .ex_valid_i     (ex_valid_i),
    .mem_req_i      (mem_req_i),
    .mem_we_i       (mem_we_i),
    .mem_size_i     (mem_size_i),
    .mem_unsigned_i (mem_unsigned_i),
    .stall_o        (stall_o),
    .data_req_o     (data_req_o),
    .data_gnt_i     (data_gnt_i),
    .data_rvalid_i  (data_rvalid_i),
    .data_addr_o    (data_addr_o),
    .data_we_o      (data_we_o),
    .data_be_o      (data_be_o),
    .data_wdata_o   (data_wdata_o),
    .data_rdata_i   (data_rdata_i),
    .wb_data_o      (wb_data_o),
    .wb_valid_o     (wb_valid_o),
    .misaligned_o   (misaligned_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, then let combinational paths settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_op(input logic [31:0] addr, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd);
    ex_valid_i = 1'b1; mem_req_i = 1'b1; ex_data_i = addr; mem_we_i = we;
    mem_size_i = size; mem_unsigned_i = uns; rdata2_store_i = wd;
  endtask

  task automatic idle_inputs();
    ex_valid_i = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0; data_gnt_i = 1'b0;
    data_rvalid_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ex_data_i = '0; rdata2_store_i = '0; data_rdata_i = '0;
    mem_size_i = MEM_BYTE; mem_unsigned_i = 1'b0;
    idle_inputs();
    #2;
    chk("rst_wb_data", wb_data_o, 32'h0);
    chk("rst_wb_valid", {31'b0, wb_valid_o}, 32'h0);
    chk("rst_misaligned", {31'b0, misaligned_o}, 32'h0);
    chk("rst_req", {31'b0, data_req_o}, 32'h0);
    chk("rst_we", {31'b0, data_we_o}, 32'h0);
    chk("rst_stall", {31'b0, stall_o}, 32'h0);
    chk("rst_be", {28'b0, data_be_o}, 32'h0);
    chk("rst_addr", data_addr_o, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // ALU passthrough
    ex_valid_i = 1'b1; mem_req_i = 1'b0; ex_data_i = 32'h1234_5678; #1;
    chk("alu_req", {31'b0, data_req_o}, 32'h0);
    chk("alu_stall", {31'b0, stall_o}, 32'h0);
    step(); idle_inputs(); #1;
    chk("alu_wb_valid", {31'b0, wb_valid_o}, 32'h1);
    chk("alu_wb_data", wb_data_o, 32'h1234_5678);
    step();
    chk("alu_wb_valid_drop", {31'b0, wb_valid_o}, 32'h0);

    // LB signed at 0x103, immediate grant
    mem_op(32'h0000_0103, 1'b0, MEM_BYTE, 1'b0, 32'h0); data_gnt_i = 1'b1; #1;
    chk("lb_req", {31'b0, data_req_o}, 32'h1);
    chk("lb_addr", data_addr_o, 32'h0000_0100);
    chk("lb_be", {28'b0, data_be_o}, 32'h8);
    chk("lb_stall0", {31'b0, stall_o}, 32'h1);
    step(); data_gnt_i = 1'b0; #1;
    chk("lb_req_off", {31'b0, data_req_o}, 32'h0);
    chk("lb_stall_wait", {31'b0, stall_o}, 32'h1);
    data_rvalid_i = 1'b1; data_rdata_i = 32'h8000_0000; #1;
    chk("lb_stall_rvalid", {31'b0, stall_o}, 32'h0);
    step(); idle_inputs(); #1;
    chk("lb_wb_valid", {31'b0, wb_valid_o}, 32'h1);
    chk("lb_wb_data", wb_data_o, 32'hFFFF_FF80);
    step();

    // LBU at 0x103
    mem_op(32'h0000_0103, 1'b0, MEM_BYTE, 1'b1, 32'h0); data_gnt_i = 1'b1;
    step(); data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h8000_0000;
    step(); idle_inputs(); #1;
    chk("lbu_wb_valid", {31'b0, wb_valid_o}, 32'h1);
    chk("lbu_wb_data", wb_data_o, 32'h0000_0080);
    step();

    // SH at 0x202, grant delayed three cycles
    mem_op(32'h0000_0202, 1'b1, MEM_HALF, 1'b0, 32'h0000_ABCD); #1;
    chk("sh_addr", data_addr_o, 32'h0000_0200);
    chk("sh_be", {28'b0, data_be_o}, 32'hC);
    chk("sh_wdata", data_wdata_o, 32'hABCD_ABCD);
    chk("sh_we", {31'b0, data_we_o}, 32'h1);
    req_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) data_gnt_i = 1'b1;
      #1;
      if (data_req_o) req_cycles++;
      chk("sh_stall_gnt", {31'b0, stall_o}, 32'h1);
      step();
    end
    data_gnt_i = 1'b0; #1;
    chk("sh_req_cycles", req_cycles, 32'd4);
    chk("sh_req_off", {31'b0, data_req_o}, 32'h0);
    chk("sh_stall_rv", {31'b0, stall_o}, 32'h1);
    step(); data_rvalid_i = 1'b1; data_rdata_i = 32'h5555_5555; #1;
    chk("sh_stall_release", {31'b0, stall_o}, 32'h0);
    step(); idle_inputs(); #1;
    chk("sh_wb_valid", {31'b0, wb_valid_o}, 32'h1);
    chk("sh_wb_data_kept", wb_data_o, 32'h0000_0080);
    step();

    // LH signed at 0x102
    mem_op(32'h0000_0102, 1'b0, MEM_HALF, 1'b0, 32'h0); data_gnt_i = 1'b1; #1;
    chk("lh_be", {28'b0, data_be_o}, 32'hC);
    step(); data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h8765_1234;
    step(); idle_inputs(); #1;
    chk("lh_wb_data", wb_data_o, 32'hFFFF_8765);
    step();

    // Reset while waiting for rvalid, then a stray rvalid
    mem_op(32'h0000_0100, 1'b0, MEM_WORD, 1'b0, 32'h0); data_gnt_i = 1'b1;
    step(); idle_inputs(); rst_n = 1'b0; #1;
    chk("rrst_wb_data", wb_data_o, 32'h0);
    chk("rrst_stall", {31'b0, stall_o}, 32'h0);
    chk("rrst_req", {31'b0, data_req_o}, 32'h0);
    step(); rst_n = 1'b1;
    step(); data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFE_F00D; #1;
    chk("rrst_stray_stall", {31'b0, stall_o}, 32'h0);
    step(); data_rvalid_i = 1'b0; #1;
    chk("rrst_no_wb_valid", {31'b0, wb_valid_o}, 32'h0);
    chk("rrst_wb_data_zero", wb_data_o, 32'h0);
    chk("rrst_no_req", {31'b0, data_req_o}, 32'h0);
    step();

    // LW at 0x102
    mem_op(32'h0000_0102, 1'b0, MEM_WORD, 1'b0, 32'h0); #1;
`ifdef MEM_MISALIGN_TRAP_EN
    chk("lw_mis_req", {31'b0, data_req_o}, 32'h0);
    chk("lw_mis_stall", {31'b0, stall_o}, 32'h0);
    step(); idle_inputs(); #1;
    chk("lw_mis_pulse", {31'b0, misaligned_o}, 32'h1);
    chk("lw_mis_wb_valid", {31'b0, wb_valid_o}, 32'h0);
    step();
    chk("lw_mis_pulse_drop", {31'b0, misaligned_o}, 32'h0);
`else
    chk("lw_req", {31'b0, data_req_o}, 32'h1);
    chk("lw_addr", data_addr_o, 32'h0000_0100);
    chk("lw_be", {28'b0, data_be_o}, 32'hF);
    data_gnt_i = 1'b1;
    step(); data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'hDEAD_BEEF;
    step(); idle_inputs(); #1;
    chk("lw_wb_valid", {31'b0, wb_valid_o}, 32'h1);
    chk("lw_wb_data", wb_data_o, 32'hDEAD_BEEF);
    chk("lw_misaligned_tied", {31'b0, misaligned_o}, 32'h0);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
